// File: rtl/demux_router.sv
// demux_router: 1-to-NR_OUT registered demux with a one-entry holding slot per output channel.
// Optional DEMUX_ROUTER_STATS_EN adds a saturating xfer_cnt of accepted in-range beats.
module demux_router #(
  parameter int NR_OUT   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [KEY_LEN-1:0]           in_sel,
  input  logic [DATA_LEN-1:0]          in_data,
  output logic [NR_OUT-1:0]            out_valid,
  input  logic [NR_OUT-1:0]            out_ready,
  output logic [NR_OUT*DATA_LEN-1:0]   out_data,
  output logic                         sel_err
`ifdef DEMUX_ROUTER_STATS_EN
  ,
  output logic [15:0]                  xfer_cnt
`endif
);
  logic              in_range;
  logic              sel_full;
  logic              sel_rdy;
  logic              fire;
  logic [NR_OUT-1:0] fill;
  logic [NR_OUT-1:0] drain;
  assign in_range = (KEY_LEN+1)'(in_sel) < (KEY_LEN+1)'(NR_OUT);
  assign fire     = in_valid & in_ready;
  always_comb begin
    sel_full = 1'b0;
    sel_rdy  = 1'b0;
    fill     = '0;
    drain    = '0;
    for (int n = 0; n < NR_OUT; n++) begin
      if (in_sel == KEY_LEN'(n)) begin
        sel_full = out_valid[n];
        sel_rdy  = out_ready[n];
      end
      fill[n]  = fire & in_range & (in_sel == KEY_LEN'(n));
      drain[n] = out_valid[n] & out_ready[n];
    end
    in_ready = ~in_range | ~sel_full | sel_rdy;
  end
  // Fill wins over drain so a full slot being drained can take the next beat without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      sel_err   <= 1'b0;
    end else begin
      sel_err <= in_valid & ~in_range;
      for (int n = 0; n < NR_OUT; n++) begin
        if (fill[n]) begin
          out_valid[n]                        <= 1'b1;
          out_data[n*DATA_LEN +: DATA_LEN]    <= in_data;
        end else if (drain[n]) begin
          out_valid[n] <= 1'b0;
        end
      end
    end
  end
`ifdef DEMUX_ROUTER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) xfer_cnt <= '0;
    else if (fire && in_range && xfer_cnt != 16'hFFFF) xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif
endmodule
